// File: rtl/serial_adder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// serial_adder : bit-serial WIDTH-bit adder, one full_adder + carry FF, LSB first
// Revision 1.0
// ---------------------------------------------------------------------------

module full_adder (
  input  logic a,
  input  logic b,
  input  logic carry_in,
  output logic sum,
  output logic carry_out
);
  assign sum       = a ^ b ^ carry_in;
  assign carry_out = (a & b) | (carry_in & (a ^ b));
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh, res_sh, res_nxt;
  logic             c_ff;
  logic [CW-1:0]    cnt;
  logic             fa_sum, fa_carry_out;
  logic             last_bit;

  full_adder u_fa (
    .a         (a_sh[0]),
    .b         (b_sh[0]),
    .carry_in  (c_ff),
    .sum       (fa_sum),
    .carry_out (fa_carry_out)
  );

  // New bit enters at the MSB; the cast also covers WIDTH == 1
  assign res_nxt  = WIDTH'({fa_sum, res_sh} >> 1);
  assign last_bit = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        busy = 1'b1;
        if (last_bit) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh      <= '0;
      b_sh      <= '0;
      res_sh    <= '0;
      c_ff      <= 1'b0;
      cnt       <= '0;
      sum       <= '0;
      carry_out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sh   <= a;
            b_sh   <= b;
            c_ff   <= carry_in;
            cnt    <= '0;
            res_sh <= '0;
          end
        end
        RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          res_sh <= res_nxt;
          c_ff   <= fa_carry_out;
          cnt    <= cnt + 1'b1;
          // Outputs only ever show a finished result
          if (last_bit) begin
            sum       <= res_nxt;
            carry_out <= fa_carry_out;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

`default_nettype wire
